gated_pipe_stage: RTL

- Elastic two-stage pipeline with valid/ready handshake.
- Sits directly upstream of the predicated gate pipeline and supplies its `pred`/`x` operands, already registered and gated.
- Each accepted beat carries a predicate and a data word. The block registers the beat, gates the data (zero when predicate is low) through a gate-buffer cell, and presents the result downstream under backpressure.
- Keeps a saturating count of gated-off beats for debug.

---
 rtl/gated_pipe_stage_pkg.sv | 14 +
 rtl/br_gate_buf.sv | 10 +
 rtl/gated_pipe_gate.sv | 18 +
 rtl/gated_pipe_stage.sv | 94 +++++++++
 4 files changed

// File: rtl/gated_pipe_stage_pkg.sv
// Shared types and default widths for the gated pipe stage.
package gated_pipe_stage_pkg;

  localparam int PKG_DATA_W = 8;
  localparam int PKG_CNT_W  = 16;

  typedef struct packed {
    logic                  pred;
    logic [PKG_DATA_W-1:0] data;
  } beat_t;

  localparam logic [PKG_CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/br_gate_buf.sv
// Single-bit gate cell; kept as its own instance so synthesis does not fold the gate away.
module br_gate_buf (
  input  logic i_a,
  input  logic i_en,
  output logic o_y
);

  assign o_y = i_a & i_en;

endmodule

// File: rtl/gated_pipe_gate.sv
// Combinational data gate: every bit is ANDed with the predicate through a br_gate_buf cell.
module gated_pipe_gate #(
  parameter int DATA_W = 8
) (
  input  logic              i_pred,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  for (genvar g = 0; g < DATA_W; g++) begin : g_bit
    br_gate_buf u_buf (
      .i_a  (i_data[g]),
      .i_en (i_pred),
      .o_y  (o_data[g])
    );
  end

endmodule

// File: rtl/gated_pipe_stage.sv
// Elastic two-stage valid/ready pipeline that gates data by predicate and counts gated-off beats.
// Optional protocol assertions are enabled with GATED_PIPE_STAGE_ASSERT_EN.
module gated_pipe_stage
  import gated_pipe_stage_pkg::*;
#(
  parameter int DATA_W = $bits(beat_t) - 1,
  parameter int CNT_W  = $bits(CNT_MAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_pred,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_pred,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  gated_cnt
);

  typedef struct packed {
    logic              valid;
    logic              pred;
    logic [DATA_W-1:0] data;
  } stage_t;

  localparam logic [CNT_W-1:0] L_CNT_MAX = '1;

  stage_t            r_s0;
  stage_t            r_s1;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_s0_ready;
  logic              w_s1_ready;
  logic              w_in_hs;
  logic [DATA_W-1:0] w_gated;

  assign w_s1_ready = !r_s1.valid || out_ready;
  assign w_s0_ready = !r_s0.valid || w_s1_ready;
  // Report ready while in reset so upstream sees an empty stage; capture is still blocked by rst.
  assign in_ready   = rst || w_s0_ready;
  assign w_in_hs    = in_valid && w_s0_ready;

  gated_pipe_gate #(
    .DATA_W (DATA_W)
  ) u_gate (
    .i_pred (r_s0.pred),
    .i_data (r_s0.data),
    .o_data (w_gated)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0  <= '0;
      r_s1  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_in_hs) begin
        r_s0 <= '{valid: 1'b1, pred: in_pred, data: in_data};
      end else if (w_s1_ready) begin
        r_s0.valid <= 1'b0;
      end

      if (r_s0.valid && w_s1_ready) begin
        r_s1 <= '{valid: 1'b1, pred: r_s0.pred, data: w_gated};
      end else if (out_ready) begin
        r_s1.valid <= 1'b0;
      end

      if (w_in_hs && !in_pred && (r_cnt != L_CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign out_valid = r_s1.valid;
  assign out_pred  = r_s1.pred;
  assign out_data  = r_s1.data;
  assign gated_cnt = r_cnt;

`ifdef GATED_PIPE_STAGE_ASSERT_EN
  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> ($stable(out_valid) && $stable(out_pred) && $stable(out_data)));

  a_in_hold: assert property (@(posedge clk) disable iff (rst)
    (in_valid && !in_ready) |=> in_valid);

  a_gated_zero: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_pred) |-> (out_data == '0));
`else
  // Assertions are not elaborated in this build.
`endif

endmodule
